pad_group_arbiter: RTL and testbench

PAD_GROUP_ARBITER -- requirements
Module: pad_group_arbiter

---
 rtl/pad_group_arbiter.sv | 136 +++++++++++++
 tb/tb_pad_group_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pad_group_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pad_group_arbiter
// Description : Round-robin ownership arbiter that muxes one shared pad group
//               between requesters, with a dead-time turnaround between owners.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_group_arbiter #(
  parameter int          N_REQ      = 4,
  parameter int          N_PADS     = 8,
  parameter int          TURNAROUND = 2,
  parameter logic [15:0] MAX_HOLD   = 16'd0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0]            rel_i,
  input  logic [N_REQ*N_PADS-1:0]     req_out_i,
  input  logic [N_REQ*N_PADS-1:0]     req_oe_i,
  input  logic [N_PADS-1:0]           pad_in_i,
  output logic [N_REQ-1:0]            gnt_o,
  output logic [$clog2(N_REQ)-1:0]    owner_o,
  output logic                        owner_valid_o,
  output logic [N_PADS-1:0]           pad_out_o,
  output logic [N_PADS-1:0]           pad_oe_o,
  output logic [N_REQ*N_PADS-1:0]     req_in_o,
  output logic                        preempt_o
);

  localparam int         c_OW_W      = $clog2(N_REQ);
  localparam logic [3:0] c_TURN_LAST = 4'(TURNAROUND - 1);
  localparam logic [15:0] c_HOLD_LAST = MAX_HOLD - 16'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWNED = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_OW_W-1:0]   r_rr;
  logic [c_OW_W-1:0]   r_owner;
  logic [N_REQ-1:0]    r_gnt;
  logic                r_owner_valid;
  logic                r_preempt;
  logic [15:0]         r_hold;
  logic [3:0]          r_turn;

  logic                w_pick_valid;
  logic [c_OW_W-1:0]   w_pick;
  logic                w_voluntary;
  logic                w_forced;
  logic [c_OW_W-1:0]   w_next_rr;
  logic                w_active;

  // Scan from the farthest offset down so the nearest request at/after rr wins.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[(int'(r_rr) + i) % N_REQ]) begin
        w_pick_valid = 1'b1;
        w_pick       = c_OW_W'((int'(r_rr) + i) % N_REQ);
      end
    end
  end

  assign w_voluntary = rel_i[r_owner] | ~req_i[r_owner];
  assign w_forced    = (MAX_HOLD != 16'd0) && (r_hold == c_HOLD_LAST);
  assign w_next_rr   = (r_owner == c_OW_W'(N_REQ - 1)) ? '0 : r_owner + c_OW_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_rr          <= '0;
      r_owner       <= '0;
      r_gnt         <= '0;
      r_owner_valid <= 1'b0;
      r_preempt     <= 1'b0;
      r_hold        <= '0;
      r_turn        <= '0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_state       <= S_OWNED;
            r_owner       <= w_pick;
            r_gnt         <= N_REQ'(1) << w_pick;
            r_owner_valid <= 1'b1;
            r_hold        <= '0;
          end
        end
        S_OWNED: begin
          if (w_voluntary || w_forced) begin
            r_state       <= S_TURN;
            r_rr          <= w_next_rr;
            r_gnt         <= '0;
            r_owner_valid <= 1'b0;
            r_turn        <= '0;
            r_preempt     <= w_forced & ~w_voluntary;
          end else if (r_hold != 16'hFFFF) begin
            r_hold <= r_hold + 16'd1;
          end
        end
        S_TURN: begin
          if (r_turn == c_TURN_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_turn <= r_turn + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gate with reset so enables drop immediately, not one edge later.
  assign w_active = r_owner_valid & ~rst_i;

  assign gnt_o         = r_gnt;
  assign owner_o       = r_owner;
  assign owner_valid_o = r_owner_valid;
  assign preempt_o     = r_preempt;
  assign pad_out_o     = w_active ? req_out_i[r_owner*N_PADS +: N_PADS] : '0;
  assign pad_oe_o      = w_active ? req_oe_i[r_owner*N_PADS +: N_PADS] : '0;

  generate
    for (genvar k = 0; k < N_REQ; k++) begin : g_req_in
      assign req_in_o[k*N_PADS +: N_PADS] =
        (w_active && (r_owner == c_OW_W'(k))) ? pad_in_i : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pad_group_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_group_arbiter
// Description : Directed self-checking bench for pad_group_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_group_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  rel;
  logic [31:0] req_out;
  logic [31:0] req_oe;
  logic [7:0]  pad_in;

  logic [3:0]  gnt,  gnt2;
  logic [1:0]  owner, owner2;
  logic        ov,   ov2;
  logic [7:0]  pout, pout2;
  logic [7:0]  poe,  poe2;
  logic [31:0] rin,  rin2;
  logic        pre,  pre2;

  int checks = 0;
  int errors = 0;

  pad_group_arbiter #(.N_REQ(4), .N_PADS(8), .TURNAROUND(2), .MAX_HOLD(16'd0)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .rel_i(rel), .req_out_i(req_out),
    .req_oe_i(req_oe), .pad_in_i(pad_in), .gnt_o(gnt), .owner_o(owner),
    .owner_valid_o(ov), .pad_out_o(pout), .pad_oe_o(poe), .req_in_o(rin),
    .preempt_o(pre)
  );

  pad_group_arbiter #(.N_REQ(4), .N_PADS(8), .TURNAROUND(2), .MAX_HOLD(16'd5)) dut_mh (
    .clk_i(clk), .rst_i(rst), .req_i(req), .rel_i(rel), .req_out_i(req_out),
    .req_oe_i(req_oe), .pad_in_i(pad_in), .gnt_o(gnt2), .owner_o(owner2),
    .owner_valid_o(ov2), .pad_out_o(pout2), .pad_oe_o(poe2), .req_in_o(rin2),
    .preempt_o(pre2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; rel = '0;
    req_out = 32'hFFFF_FFFF; req_oe = 32'hFFFF_FFFF; pad_in = 8'hFF;
    tick(); tick();
    checks++; if (poe !== 8'h00) begin errors++; $display("FAIL reset_poe_during: got %h expected %h", poe, 8'h00); end
    rst = 1'b0;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected %0d", owner, 0); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_owner_valid: got %b expected %b", ov, 1'b0); end
    checks++; if (pre !== 1'b0) begin errors++; $display("FAIL reset_preempt: got %b expected %b", pre, 1'b0); end
    checks++; if (rin !== 32'h0) begin errors++; $display("FAIL reset_req_in: got %h expected %h", rin, 32'h0); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (gnt !== 4'b0000 || ov !== 1'b0) begin errors++; $display("FAIL idle_no_grant: got gnt=%b ov=%b expected 0000/0", gnt, ov); end
    end
  endtask

  task automatic test_grant();
    req = 4'b1010;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL grant_latency: got %b expected %b", gnt, 4'b0000); end
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL grant_gnt: got %b expected %b", gnt, 4'b0010); end
    checks++; if (owner !== 2'd1) begin errors++; $display("FAIL grant_owner: got %0d expected %0d", owner, 1); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL grant_owner_valid: got %b expected %b", ov, 1'b1); end
    checks++; if (poe !== 8'hFF) begin errors++; $display("FAIL grant_poe: got %h expected %h", poe, 8'hFF); end
  endtask

  task automatic test_release_turn();
    rel = 4'b0010;
    tick();
    rel = 4'b0000;
    checks++; if (ov !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL turn1_state: got ov=%b gnt=%b expected 0/0000", ov, gnt); end
    checks++; if (poe !== 8'h00) begin errors++; $display("FAIL turn1_poe: got %h expected %h", poe, 8'h00); end
    checks++; if (rin !== 32'h0) begin errors++; $display("FAIL turn1_req_in: got %h expected %h", rin, 32'h0); end
    tick();
    checks++; if (gnt !== 4'b0000 || poe !== 8'h00) begin errors++; $display("FAIL turn2_state: got gnt=%b poe=%h expected 0000/00", gnt, poe); end
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_after_turn: got %b expected %b", gnt, 4'b0000); end
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL regrant_gnt: got %b expected %b", gnt, 4'b1000); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL regrant_owner: got %0d expected %0d", owner, 3); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] prev = 2'd3;
    int n;
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      rel = 4'b0001 << prev;
      tick();
      rel = 4'b0000;
      n = 0;
      while (ov !== 1'b1 && n < 10) begin tick(); n++; end
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL rr_timeout: got ov=%b expected %b", ov, 1'b1); end
      checks++; if (owner !== exp_seq[s] || n != 3) begin errors++; $display("FAIL rr_owner step %0d: got owner=%0d after %0d cycles expected %0d after 3", s, owner, n, exp_seq[s]); end
      prev = exp_seq[s];
    end
  endtask

  task automatic test_ignore_rel();
    rel = 4'b1000;
    tick();
    rel = 4'b0000;
    checks++; if (ov !== 1'b1 || owner !== 2'd0 || gnt !== 4'b0001) begin errors++; $display("FAIL ignore_rel: got ov=%b owner=%0d gnt=%b expected 1/0/0001", ov, owner, gnt); end
    checks++; if (pre !== 1'b0) begin errors++; $display("FAIL ignore_rel_preempt: got %b expected %b", pre, 1'b0); end
    tick();
    checks++; if (ov !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL ignore_rel_hold: got ov=%b owner=%0d expected 1/0", ov, owner); end
  endtask

  task automatic test_pad_mux();
    do_reset();
    req = 4'b0100;
    req_oe = 32'hFFF0_0F55;
    req_out = 32'h11A5_2233;
    pad_in = 8'h3C;
    #1;
    checks++; if (rin !== 32'h0 || poe !== 8'h00) begin errors++; $display("FAIL mux_idle: got rin=%h poe=%h expected 0/00", rin, poe); end
    tick();
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL mux_owner: got %0d expected %0d", owner, 2); end
    checks++; if (poe !== 8'hF0) begin errors++; $display("FAIL mux_poe: got %h expected %h", poe, 8'hF0); end
    checks++; if (pout !== 8'hA5) begin errors++; $display("FAIL mux_pout: got %h expected %h", pout, 8'hA5); end
    checks++; if (rin !== 32'h003C_0000) begin errors++; $display("FAIL mux_req_in: got %h expected %h", rin, 32'h003C_0000); end
    pad_in = 8'hC3;
    #1;
    checks++; if (rin !== 32'h00C3_0000) begin errors++; $display("FAIL mux_req_in_comb: got %h expected %h", rin, 32'h00C3_0000); end
  endtask

  task automatic test_reset_mid();
    req = 4'b1111;
    tick();
    checks++; if (ov !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL mid_pre: got ov=%b owner=%0d expected 1/2", ov, owner); end
    rst = 1'b1;
    #1;
    checks++; if (poe !== 8'h00 || rin !== 32'h0) begin errors++; $display("FAIL mid_rst_comb: got poe=%h rin=%h expected 00/0", poe, rin); end
    tick();
    checks++; if (gnt !== 4'b0000 || owner !== 2'd0 || ov !== 1'b0 || pre !== 1'b0) begin errors++; $display("FAIL mid_rst_outputs: got gnt=%b owner=%0d ov=%b pre=%b expected all 0", gnt, owner, ov, pre); end
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0001 || owner !== 2'd0) begin errors++; $display("FAIL mid_rst_regrant: got gnt=%b owner=%0d expected 0001/0", gnt, owner); end
    rel = 4'b0001;
    tick();
    rel = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ov !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL turn_rst_outputs: got ov=%b gnt=%b expected 0/0000", ov, gnt); end
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL turn_rst_no_turnaround: got %b expected %b", gnt, 4'b0001); end
  endtask

  task automatic test_max_hold();
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 1; c <= 5; c++) begin
      checks++; if (ov2 !== 1'b1 || pre2 !== 1'b0) begin errors++; $display("FAIL maxhold_cycle %0d: got ov=%b pre=%b expected 1/0", c, ov2, pre2); end
      tick();
    end
    checks++; if (ov2 !== 1'b0 || pre2 !== 1'b1 || gnt2 !== 4'b0000) begin errors++; $display("FAIL maxhold_release: got ov=%b pre=%b gnt=%b expected 0/1/0000", ov2, pre2, gnt2); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL nolimit_still_owned: got %b expected %b", ov, 1'b1); end
    tick();
    checks++; if (pre2 !== 1'b0 || ov2 !== 1'b0) begin errors++; $display("FAIL maxhold_pulse_once: got pre=%b ov=%b expected 0/0", pre2, ov2); end
  endtask

  task automatic test_simul_release();
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 1; c < 5; c++) tick();
    rel = 4'b0001;
    tick();
    rel = 4'b0000;
    checks++; if (ov2 !== 1'b0 || pre2 !== 1'b0) begin errors++; $display("FAIL simul_release: got ov=%b pre=%b expected 0/0", ov2, pre2); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL simul_release_nolimit: got %b expected %b", ov, 1'b0); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_grant();
    test_release_turn();
    test_round_robin();
    test_ignore_rel();
    test_pad_mux();
    test_reset_mid();
    test_max_hold();
    test_simul_release();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
